// File: rtl/usb_burst_ctrl.sv
// Burst controller around the FT232H async-FIFO block: each received byte is a start
// address; replies with an optional header byte plus NR_WORDS bytes read from memory.
module usb_burst_ctrl #(
  parameter int NR_WORDS = 16,
  parameter int ADDR_W   = 8,
  parameter int SEND_HDR = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              byte_received,
  input  logic [7:0]        read_data,
  input  logic              tx_done,
  output logic              write_request,
  output logic [7:0]        write_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  output logic              busy,
  output logic              burst_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    RD    = 3'd2,
    LATCH = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] NR_W = 16'(NR_WORDS);

  state_t              state_q;
  logic [15:0]         left_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                write_request_q;
  logic [7:0]          write_data_q;
  logic                mem_rd_en_q;
  logic                busy_q;
  logic                burst_done_q;
  logic                overrun_q;

  // Burst sequencer; mem_addr_q doubles as the running burst address.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      left_q          <= 16'd0;
      mem_addr_q      <= '0;
      write_request_q <= 1'b0;
      write_data_q    <= 8'h00;
      mem_rd_en_q     <= 1'b0;
      busy_q          <= 1'b0;
      burst_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      if (byte_received && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (byte_received) begin
            mem_addr_q <= ADDR_W'(read_data);
            left_q     <= NR_W;
            busy_q     <= 1'b1;
            if (SEND_HDR != 0) begin
              write_data_q    <= read_data;
              write_request_q <= 1'b1;
              state_q         <= HDR;
            end else begin
              mem_rd_en_q <= 1'b1;
              state_q     <= RD;
            end
          end
        end
        HDR: begin
          if (tx_done) begin
            write_request_q <= 1'b0;
            mem_rd_en_q     <= 1'b1;
            state_q         <= RD;
          end
        end
        RD: begin
          state_q <= LATCH;
        end
        // Memory data is valid here, one cycle after the read enable.
        LATCH: begin
          write_data_q    <= mem_rd_data;
          write_request_q <= 1'b1;
          state_q         <= SEND;
        end
        SEND: begin
          if (tx_done) begin
            write_request_q <= 1'b0;
            left_q          <= left_q - 16'd1;
            mem_addr_q      <= mem_addr_q + ADDR_W'(1);
            if (left_q == 16'd1) begin
              burst_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              mem_rd_en_q <= 1'b1;
              state_q     <= RD;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          write_request_q <= 1'b0;
          busy_q          <= 1'b0;
          state_q         <= IDLE;
        end
      endcase
    end
  end

  assign write_request = write_request_q;
  assign write_data    = write_data_q;
  assign mem_addr      = mem_addr_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign busy          = busy_q;
  assign burst_done    = burst_done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_usb_burst_ctrl.sv
// Bench for usb_burst_ctrl: DUT A (header on) checked every cycle against a
// transaction-level expectation queue; DUT B (header off) checked with directed vectors.
module tb_usb_burst_ctrl;

  logic       CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic       reset;
  logic       br_a, tx_a, spur_tx, wr_a, rd_en_a, busy_a, bd_a, ovr_a;
  logic [7:0] rd_a, wdata_a, mem_addr_a, mem_data_a;
  logic       tx_done_a;
  logic       br_b, tx_b, wr_b, rd_en_b, busy_b, bd_b, ovr_b;
  logic [7:0] rd_b, wdata_b, mem_addr_b, mem_data_b;

  assign tx_done_a = tx_a | spur_tx;

  usb_burst_ctrl #(.NR_WORDS(4), .ADDR_W(8), .SEND_HDR(1)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .byte_received(br_a), .read_data(rd_a),
    .tx_done(tx_done_a), .write_request(wr_a), .write_data(wdata_a),
    .mem_addr(mem_addr_a), .mem_rd_en(rd_en_a), .mem_rd_data(mem_data_a),
    .busy(busy_a), .burst_done(bd_a), .overrun(ovr_a));

  usb_burst_ctrl #(.NR_WORDS(4), .ADDR_W(8), .SEND_HDR(0)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .byte_received(br_b), .read_data(rd_b),
    .tx_done(tx_b), .write_request(wr_b), .write_data(wdata_b),
    .mem_addr(mem_addr_b), .mem_rd_en(rd_en_b), .mem_rd_data(mem_data_b),
    .busy(busy_b), .burst_done(bd_b), .overrun(ovr_b));

  // Synchronous byte memories holding mem[i] = i ^ 0xA5
  always @(posedge CLOCK_50) begin
    if (rd_en_a) mem_data_a <= mem_addr_a ^ 8'hA5;
    if (rd_en_b) mem_data_b <= mem_addr_b ^ 8'hA5;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  logic [7:0] exp_wr[$];
  logic [7:0] exp_addr[$];
  logic [7:0] wlog[$];
  logic [7:0] alog[$];
  logic [7:0] blog[$];
  int         exp_bursts = 0;
  int         bd_cnt_a = 0;
  int         rises_a = 0;
  int         hi_a = 0;
  int         hi_max = 0;
  int         stall_target = -1;
  int         hb = 0;
  logic       prev_wr_a = 1'b0;
  logic [7:0] held_a = 8'h00;
  logic [7:0] exp_v;

  // Compare process for DUT A: every new write and every read must match the queues
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (wr_a && !prev_wr_a) begin
          wlog.push_back(wdata_a);
          if (exp_wr.size() == 0) fail_now("unexpected_write_request");
          else begin
            exp_v = exp_wr.pop_front();
            check("write_data", {24'd0, wdata_a}, {24'd0, exp_v});
          end
          held_a = wdata_a;
        end else if (wr_a) begin
          check("wdata_hold", {24'd0, wdata_a}, {24'd0, held_a});
          check("no_read_while_req", {31'd0, rd_en_a}, 32'd0);
        end
        if (rd_en_a) begin
          alog.push_back(mem_addr_a);
          if (exp_addr.size() == 0) fail_now("unexpected_mem_read");
          else begin
            exp_v = exp_addr.pop_front();
            check("mem_addr", {24'd0, mem_addr_a}, {24'd0, exp_v});
          end
        end
        if (bd_a) bd_cnt_a++;
      end
      prev_wr_a = wr_a;
    end
  end

  // Interface responder for DUT A: tx_done after 5 request cycles, 300 on the stalled one
  initial begin
    tx_a = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (tx_a) begin
        tx_a = 1'b0;
        if (!reset) check("req_drop_after_tx_done", {31'd0, wr_a}, 32'd0);
        hi_a = 0;
      end else if (wr_a && !reset) begin
        if (hi_a == 0) rises_a++;
        hi_a++;
        if (hi_a > hi_max) hi_max = hi_a;
        if (hi_a >= ((rises_a == stall_target) ? 300 : 5)) tx_a = 1'b1;
      end else begin
        hi_a = 0;
      end
    end
  end

  // Interface responder and write logger for DUT B
  initial begin
    tx_b = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (tx_b) begin
        tx_b = 1'b0;
        hb = 0;
      end else if (wr_b && !reset) begin
        if (hb == 0) blog.push_back(wdata_b);
        hb++;
        if (hb >= 2) tx_b = 1'b1;
      end else begin
        hb = 0;
      end
    end
  end

  task automatic send_a(input logic [7:0] b);
    logic [7:0] a;
    rd_a = b;
    br_a = 1'b1;
    exp_wr.push_back(b);
    for (int i = 0; i < 4; i++) begin
      a = b + 8'(i);
      exp_wr.push_back(a ^ 8'hA5);
      exp_addr.push_back(a);
    end
    exp_bursts++;
    @(negedge CLOCK_50);
    br_a = 1'b0;
    check("hdr_latency", {31'd0, wr_a}, 32'd1);
    check("hdr_data", {24'd0, wdata_a}, {24'd0, b});
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (bd_a !== 1'b1 && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("burst_done_seen", {31'd0, bd_a}, 32'd1);
  endtask

  task automatic end_of_burst_a(input int nwr);
    @(negedge CLOCK_50);
    check("busy_after", {31'd0, busy_a}, 32'd0);
    check("wr_queue_empty", exp_wr.size(), 32'd0);
    check("addr_queue_empty", exp_addr.size(), 32'd0);
    check("write_pulses", wlog.size(), nwr);
    check("burst_count", bd_cnt_a, exp_bursts);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_wr"}, {31'd0, wr_a}, 32'd0);
    check({tag, "_wdata"}, {24'd0, wdata_a}, 32'd0);
    check({tag, "_addr"}, {24'd0, mem_addr_a}, 32'd0);
    check({tag, "_rden"}, {31'd0, rd_en_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_bd"}, {31'd0, bd_a}, 32'd0);
    check({tag, "_ovr"}, {31'd0, ovr_a}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  logic [7:0] lit_b1[5];
  logic [7:0] lit_wrap[4];
  logic [7:0] lit_b[4];
  int         base, n, bd_base;

  initial begin
    lit_b1   = '{8'h10, 8'hB5, 8'hB4, 8'hB7, 8'hB6};
    lit_wrap = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    lit_b    = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    reset = 1'b1; br_a = 1'b0; rd_a = 8'h00; spur_tx = 1'b0; br_b = 1'b0; rd_b = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    check_idle_a("reset");
    check("reset_b_wr", {31'd0, wr_b}, 32'd0);
    check("reset_b_busy", {31'd0, busy_b}, 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);

    // Spurious tx_done while idle
    spur_tx = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    spur_tx = 1'b0;
    @(negedge CLOCK_50);
    check_idle_a("spurious");

    // Basic burst from 0x10
    wlog.delete(); alog.delete();
    send_a(8'h10);
    wait_done_a();
    end_of_burst_a(5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size()) check("burst1_literal", {24'd0, wlog[i]}, {24'd0, lit_b1[i]});

    // Address wrap
    wlog.delete(); alog.delete();
    send_a(8'hFE);
    wait_done_a();
    end_of_burst_a(5);
    check("wrap_reads", alog.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < alog.size()) check("wrap_literal", {24'd0, alog[i]}, {24'd0, lit_wrap[i]});

    // Stall on 2nd data byte
    wlog.delete(); alog.delete();
    hi_max = 0;
    stall_target = rises_a + 3;
    send_a(8'h5A);
    wait_done_a();
    stall_target = -1;
    end_of_burst_a(5);
    check("stall_length", {31'd0, (hi_max >= 300)}, 32'd1);

    // Overrun mid-burst, then new burst right after burst_done
    check("overrun_clear", {31'd0, ovr_a}, 32'd0);
    wlog.delete(); alog.delete();
    send_a(8'h20);
    repeat (8) @(negedge CLOCK_50);
    rd_a = 8'h55; br_a = 1'b1;
    @(negedge CLOCK_50);
    br_a = 1'b0;
    check("overrun_set", {31'd0, ovr_a}, 32'd1);
    wait_done_a();
    end_of_burst_a(5);
    check("overrun_sticky", {31'd0, ovr_a}, 32'd1);
    if (wlog.size() > 0) check("overrun_burst_hdr", {24'd0, wlog[0]}, 32'h20);
    wlog.delete(); alog.delete();
    send_a(8'h30);
    wait_done_a();
    end_of_burst_a(5);

    // Reset while sending data byte 2
    wlog.delete(); alog.delete();
    base = rises_a;
    send_a(8'h40);
    n = 0;
    while (rises_a < base + 3 && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("reached_byte2", {31'd0, (rises_a >= base + 3)}, 32'd1);
    @(negedge CLOCK_50);
    check("pre_reset_req", {31'd0, wr_a}, 32'd1);
    #2 reset = 1'b1;
    exp_wr.delete(); exp_addr.delete();
    #1 check("async_req_drop", {31'd0, wr_a}, 32'd0);
    @(negedge CLOCK_50);
    check_idle_a("midreset");
    reset = 1'b0;
    bd_base = bd_cnt_a;
    repeat (10) @(negedge CLOCK_50);
    check("no_residual_done", bd_cnt_a, bd_base);
    check("idle_after_reset", {31'd0, wr_a}, 32'd0);

    // DUT B: no header, address 0x00
    rd_b = 8'h00; br_b = 1'b1;
    @(negedge CLOCK_50);
    br_b = 1'b0;
    check("b_lat1_wr", {31'd0, wr_b}, 32'd0);
    check("b_lat1_rden", {31'd0, rd_en_b}, 32'd1);
    check("b_lat1_addr", {24'd0, mem_addr_b}, 32'd0);
    @(negedge CLOCK_50);
    check("b_lat2_wr", {31'd0, wr_b}, 32'd0);
    @(negedge CLOCK_50);
    check("b_lat3_wr", {31'd0, wr_b}, 32'd1);
    check("b_lat3_data", {24'd0, wdata_b}, 32'hA5);
    n = 0;
    while (bd_b !== 1'b1 && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("b_burst_done", {31'd0, bd_b}, 32'd1);
    check("b_writes", blog.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < blog.size()) check("b_literal", {24'd0, blog[i]}, {24'd0, lit_b[i]});
    // Byte arriving during the burst_done cycle is dropped
    rd_b = 8'h77; br_b = 1'b1;
    @(negedge CLOCK_50);
    br_b = 1'b0;
    check("b_drop_overrun", {31'd0, ovr_b}, 32'd1);
    check("b_drop_busy", {31'd0, busy_b}, 32'd0);
    repeat (5) @(negedge CLOCK_50);
    check("b_drop_no_req", {31'd0, wr_b}, 32'd0);
    check("b_drop_no_read", {31'd0, rd_en_b}, 32'd0);
    check("b_drop_writes", blog.size(), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_burst_ctrl.md
Name: usb_burst_ctrl

Overview:
Command/response controller that sits directly around the FT232H async-FIFO interface block. It consumes each received byte as a start address n. It then drives the interface's write port to send a burst: an optional header byte (n), then NR_WORDS data bytes read from a synchronous byte memory at addresses n, n+1, and so on. It serialises all write requests so that exactly one byte is in flight at a time.

Parameters:
NR_WORDS, 16, number of data bytes per burst (1..65535)
ADDR_W, 8, memory address width (8..16); the received byte is zero-extended to ADDR_W
SEND_HDR, 1, 1 = send address byte n before the data bytes; 0 = data only

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high
byte_received  in  1  one-cycle strobe from the USB interface; read_data valid while high
read_data  in  8  received byte
tx_done  in  1  one-cycle pulse from the USB interface in its final write-strobe cycle
write_request  out  1  level request to the USB interface to send write_data
write_data  out  8  byte to send
mem_addr  out  ADDR_W  memory read address
mem_rd_en  out  1  memory read enable; data valid on mem_rd_data one cycle later
mem_rd_data  in  8  memory read data
busy  out  1  high from burst start until return to IDLE
burst_done  out  1  one-cycle pulse when the last byte's tx_done is accepted
overrun  out  1  sticky; set when a byte arrives while busy

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock CLOCK_50. All outputs are registered.
- Reset values: write_request=0, write_data=0x00, mem_addr=0, mem_rd_en=0, busy=0, burst_done=0, overrun=0, state=IDLE, counters=0.
- States: IDLE, HDR, RD, LATCH, SEND, DONE.
- IDLE:
  - on byte_received=1, capture cur_addr=read_data (zero-extended) and left=NR_WORDS; set busy=1.
  - next state is HDR if SEND_HDR, else RD.
  - tx_done in IDLE is ignored.
- HDR: write_data=read_data, write_request=1; wait in HDR until tx_done=1. On that edge: write_request=0, go to RD.
- RD: mem_addr=cur_addr, mem_rd_en=1 for exactly one cycle; go to LATCH.
- LATCH: mem_rd_en=0. At the end of LATCH, write_data<=mem_rd_data and write_request<=1; go to SEND.
  - write_request rises 2 cycles after entering RD.
- SEND:
  - hold write_request=1 and write_data constant until tx_done=1 is sampled.
  - on that same edge: write_request=0, left<=left-1, cur_addr<=cur_addr+1 (mod 2^ADDR_W, wraps silently).
  - if left was 1, go to DONE; else go to RD.
- DONE: burst_done=1 for one cycle, busy=0, go to IDLE. A new byte is accepted in the very next cycle.
- Handshake rules:
  - write_request never re-asserts within the cycle after it drops, so the interface sees it low on return to its idle state. This guarantees no duplicate send.
  - write_data never changes while write_request=1.
- TXE stall: an unbounded wait in HDR/SEND is legal; no timeout.
- byte_received while busy=1 (any state other than IDLE): the byte is dropped, overrun<=1, and the burst is unaffected.
- byte_received and burst_done in the same cycle: the byte is dropped, overrun set (DONE counts as busy).
- tx_done outside HDR/SEND: ignored.
- Reset mid-burst: immediate return to reset values. The interface sees write_request=0 asynchronously. No residual burst_done.
- Latency: from the byte_received edge to write_request=1 is 1 cycle (SEND_HDR=1) or 3 cycles (SEND_HDR=0).

Test Plan:
- NR_WORDS=4, SEND_HDR=1, mem[i]=i^0xA5; receive 0x10, tx_done 5 cycles after each request -> writes 0x10,0xB5,0xB4,0xB7,0xB6 in order; exactly 5 write_request pulses; one burst_done; busy low afterwards.
- Wrap: ADDR_W=8, NR_WORDS=4, receive 0xFE -> mem_addr sequence 0xFE,0xFF,0x00,0x01; no extra reads.
- Stall: hold tx_done low for 300 cycles on the 2nd data byte -> write_request stays 1, write_data unchanged throughout, mem_rd_en stays 0; the burst then completes normally.
- Overrun: receive 0x20 and, mid-burst, inject byte_received with 0x55 -> overrun=1 (stays 1), burst data still from 0x20.., no burst at 0x55; byte_received in the cycle after burst_done starts a new burst.
- Reset during SEND of byte 2 -> all outputs at reset values next cycle, no burst_done. Receive 0x00 with SEND_HDR=0 -> first write_request 3 cycles after byte_received, data mem[0].
- Spurious tx_done pulses while IDLE -> no output change.
